// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and sizes for the register file writeback front end
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  // One pending register file write: destination index plus result.
  typedef struct packed {
    reg_idx_t        rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_hold_slot.sv
// rtl/wb_hold_slot.sv - one-entry holding register for a single result producer
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       producer offers in_req this cycle
//   in_ready       slot accepts this cycle (computed by the arbiter from registered state)
//   in_req         offered {rd, data}
//   drain          slot won the write port this cycle; empties at the edge
//   full           slot holds a result
//   req            slot holds a result that must be written (rd != 0)
//   held           the held {rd, data}
module wb_hold_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  input  logic    in_ready,
  input  wb_req_t in_req,
  input  logic    drain,
  output logic    full,
  output logic    req,
  output wb_req_t held
);

  logic discarding;

  // Results for x0 are dropped: they never ask for the port and leave on the next edge.
  assign discarding = full && (held.rd == '0);
  assign req        = full && (held.rd != '0);

  // A capture takes precedence over emptying so the slot refills on the edge it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      held <= '0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      held <= in_req;
    end else if (drain || discarding) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - collects ALU and load results and arbitrates them onto the register file write port
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   issue_valid, issue_rd           destination of an instruction issued this cycle
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data   load result handshake
//   wren, rdin, rd_data_in          register file write port (combinational from the granted slot)
//   busy                            bit i set while a write to xi is outstanding
//   dup_issue_err                   sticky: an issue targeted an already-busy register
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  wren,
  output logic [REG_ADDR_W-1:0] rdin,
  output logic [XLEN-1:0]       rd_data_in,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  dup_issue_err
);

  localparam logic [1:0] WAIT_MAX = 2'(MAX_WAIT);

  wb_req_t             alu_in, mem_in, alu_held, mem_held;
  logic                alu_full, mem_full;
  logic                alu_req, mem_req;
  logic                alu_grant, mem_grant;
  logic [1:0]          wait_cnt;
  logic [NUM_REGS-1:0] busy_next;
  logic                dup_hit;

  assign alu_in = '{rd: alu_rd, data: alu_data};
  assign mem_in = '{rd: mem_rd, data: mem_data};

  wb_hold_slot u_alu_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (alu_valid),
    .in_ready (alu_ready),
    .in_req   (alu_in),
    .drain    (alu_grant),
    .full     (alu_full),
    .req      (alu_req),
    .held     (alu_held)
  );

  wb_hold_slot u_mem_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (mem_valid),
    .in_ready (mem_ready),
    .in_req   (mem_in),
    .drain    (mem_grant),
    .full     (mem_full),
    .req      (mem_req),
    .held     (mem_held)
  );

  // Loads normally win; an ALU result that has lost MAX_WAIT times in a row is forced through.
  assign alu_grant = alu_req && (!mem_req || (wait_cnt == WAIT_MAX));
  assign mem_grant = mem_req && !alu_grant;

  // Ready depends only on registered slot state, never on the producers' valid.
  // A full slot that is not requesting is discarding an x0 result.
  assign alu_ready = !alu_full || alu_grant || (alu_full && !alu_req);
  assign mem_ready = !mem_full || mem_grant || (mem_full && !mem_req);

  always_comb begin
    wren       = 1'b0;
    rdin       = '0;
    rd_data_in = '0;
    if (alu_grant) begin
      wren       = 1'b1;
      rdin       = alu_held.rd;
      rd_data_in = alu_held.data;
    end else if (mem_grant) begin
      wren       = 1'b1;
      rdin       = mem_held.rd;
      rd_data_in = mem_held.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!alu_full || alu_grant) begin
      wait_cnt <= '0;
    end else if (alu_req) begin
      wait_cnt <= wait_cnt + 2'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Clear on commit, then set on issue, so a same-edge issue keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (wren) begin
      busy_next[rdin] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // An issue that lands on the very edge the previous write to that register commits
  // is a legitimate back-to-back reuse, not a duplicate.
  assign dup_hit = issue_valid && (issue_rd != '0) && busy[issue_rd]
                   && !(wren && (rdin == issue_rd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= '0;
      dup_issue_err <= 1'b0;
    end else begin
      busy <= busy_next;
      if (dup_hit) begin
        dup_issue_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - scoreboard bench for regfile_writeback
module tb_regfile_writeback;
  import regfile_pkg::*;

  localparam int MAX_WAIT = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  wren;
  logic [REG_ADDR_W-1:0] rdin;
  logic [XLEN-1:0]       rd_data_in;
  logic [NUM_REGS-1:0]   busy;
  logic                  dup_issue_err;

  regfile_writeback #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .wren          (wren),
    .rdin          (rdin),
    .rd_data_in    (rd_data_in),
    .busy          (busy),
    .dup_issue_err (dup_issue_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    reg_idx_t    rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    reg_idx_t    rd;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  // Reference model: each producer's holding slot as a queue of at most one result,
  // outstanding destinations as a bit set, and the count of consecutive ALU losses.
  ent_t      alu_q[$];
  ent_t      mem_q[$];
  wr_t       exp_q[$];
  bit [31:0] m_busy;
  bit        m_dup;
  int        m_losses;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit acc_alu, acc_mem;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic reg_idx_t rnd_rd();
    if ($urandom_range(0, 7) == 0) return '0;
    return reg_idx_t'($urandom_range(1, 31));
  endfunction

  // One clock cycle: entered just after a rising edge with inputs already driven.
  task automatic step();
    bit   a_wants, m_wants, a_wins, m_wins, a_rdy, m_rdy;
    bit   a_x0, m_x0;
    wr_t  w;
    reg_idx_t wrd;
    cyc++;
    a_x0    = (alu_q.size() > 0) && (alu_q[0].rd == 0);
    m_x0    = (mem_q.size() > 0) && (mem_q[0].rd == 0);
    a_wants = (alu_q.size() > 0) && !a_x0;
    m_wants = (mem_q.size() > 0) && !m_x0;
    if (a_wants && m_wants) a_wins = (m_losses == MAX_WAIT);
    else                    a_wins = a_wants;
    m_wins = m_wants && !a_wins;
    a_rdy  = (alu_q.size() == 0) || a_wins || a_x0;
    m_rdy  = (mem_q.size() == 0) || m_wins || m_x0;

    check("alu_ready", alu_ready, a_rdy);
    check("mem_ready", mem_ready, m_rdy);
    check("busy", busy, m_busy);
    check("dup_issue_err", dup_issue_err, m_dup);

    wrd = '0;
    if (a_wins) begin
      w.rd = alu_q[0].rd; w.data = alu_q[0].data; w.cyc = cyc;
      exp_q.push_back(w);
      wrd = alu_q[0].rd;
    end else if (m_wins) begin
      w.rd = mem_q[0].rd; w.data = mem_q[0].data; w.cyc = cyc;
      exp_q.push_back(w);
      wrd = mem_q[0].rd;
    end

    @(posedge clk);
    acc_alu = alu_valid && a_rdy;
    acc_mem = mem_valid && m_rdy;
    if (a_wins || a_x0) void'(alu_q.pop_front());
    if (m_wins || m_x0) void'(mem_q.pop_front());
    if (acc_alu) begin ent_t e; e.rd = alu_rd; e.data = alu_data; alu_q.push_back(e); end
    if (acc_mem) begin ent_t e; e.rd = mem_rd; e.data = mem_data; mem_q.push_back(e); end
    m_losses = (a_wants && !a_wins) ? m_losses + 1 : 0;
    if (issue_valid && issue_rd != 0 && m_busy[issue_rd]
        && !((a_wins || m_wins) && wrd == issue_rd)) m_dup = 1'b1;
    if (a_wins || m_wins) m_busy[wrd] = 1'b0;
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    #1;
  endtask

  // Run n cycles; each offer stays up until accepted, issues are one-shot.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (acc_alu) alu_valid = 1'b0;
      if (acc_mem) mem_valid = 1'b0;
      issue_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_wren", wren, 1'b0);
    check("rst_rdin", rdin, '0);
    check("rst_rd_data_in", rd_data_in, '0);
    check("rst_alu_ready", alu_ready, 1'b1);
    check("rst_mem_ready", mem_ready, 1'b1);
    check("rst_busy", busy, '0);
    check("rst_dup", dup_issue_err, 1'b0);
    alu_q.delete(); mem_q.delete(); exp_q.delete();
    m_busy = '0; m_dup = 1'b0; m_losses = 0;
    repeat (2) @(posedge clk);
    #1;
    alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
    rst_n = 1'b1;
    acc_alu = 1'b0; acc_mem = 1'b0;
  endtask

  // Monitor: each cycle the write port must match the scoreboard's head entry for that cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("wren_in_reset", wren, 1'b0);
      end else begin
        bit  due;
        wr_t w;
        due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check("wren", wren, due);
        if (due) begin
          w = exp_q.pop_front();
          if (wren) begin
            check("rdin", rdin, w.rd);
            check("rd_data_in", rd_data_in, w.data);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA5A5_0001;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hA5A5_0002;
    acc_alu = 1'b0; acc_mem = 1'b0;
    #1;
    do_reset();
    run(2);

    // Single ALU write to an issued destination.
    issue_valid = 1'b1; issue_rd = 5'd5;
    run(1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    run(3);

    // Simultaneous accept: load first, ALU next.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h22;
    run(4);

    // Continuous loads against one ALU result: ALU forced through after MAX_WAIT losses.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    for (int i = 0; i < 10; i++) begin
      if (!mem_valid) begin
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h700 + i;
      end
      step();
      if (acc_alu) alu_valid = 1'b0;
      if (acc_mem) mem_valid = 1'b0;
    end
    mem_valid = 1'b0;
    run(3);

    // x0 results and issues are dropped.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    issue_valid = 1'b1; issue_rd = 5'd0;
    run(3);

    // Issue on the commit edge is legal; a second issue before commit is a duplicate.
    issue_valid = 1'b1; issue_rd = 5'd6;
    run(1);
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    run(1);
    issue_valid = 1'b1; issue_rd = 5'd6;
    run(2);
    issue_valid = 1'b1; issue_rd = 5'd6;
    run(3);

    // Reset with both slots full discards them.
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAAAA;
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'hBBBB;
    run(1);
    do_reset();
    run(2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (!alu_valid) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd = rnd_rd(); alu_data = $urandom;
      end
      if (!mem_valid) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd = rnd_rd(); mem_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd = rnd_rd();
      step();
      if (acc_alu) alu_valid = 1'b0;
      if (acc_mem) mem_valid = 1'b0;
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 8 && (alu_valid || mem_valid); i++) run(1);
    alu_valid = 1'b0; mem_valid = 1'b0;
    run(6);
    check("scoreboard_drained", exp_q.size(), 0);
    check("alu_slot_drained", alu_q.size(), 0);
    check("mem_slot_drained", mem_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
